// File: rtl/axis_cmult_bf_pipe.sv
// Complex beamforming multiplier: one signed complex weight applied to every lane of an
// AXI-Stream beat, 3-stage back-pressurable pipeline with round/saturate and frame-aligned weights.
module axis_cmult_bf_pipe #(
  parameter int SAMPLES      = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int WEIGHT_FRAC  = 6,
  parameter int ROUND        = 1,
  parameter int SATURATE     = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WEIGHT_WIDTH-1:0]             w_real,
  input  logic [WEIGHT_WIDTH-1:0]             w_imag,
  input  logic                                w_load,
  output logic                                w_pending,
  input  logic [SAMPLES*SAMPLE_WIDTH-1:0]     s_axis_real_tdata,
  input  logic [SAMPLES*SAMPLE_WIDTH-1:0]     s_axis_imag_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic                                s_axis_tlast,
  output logic [SAMPLES*SAMPLE_WIDTH-1:0]     m_axis_real_tdata,
  output logic [SAMPLES*SAMPLE_WIDTH-1:0]     m_axis_imag_tdata,
  output logic [SAMPLES*SAMPLE_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic                                ovf_sticky,
  input  logic                                ovf_clear
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int PW = SW + WW;
  localparam int DW = SAMPLES * SW;
  localparam int KW = DW / 8;

  localparam logic signed [WW-1:0] W_ONE   = WW'(1 << WEIGHT_FRAC);
  localparam logic signed [PW:0]   RND     = (ROUND != 0) ? (PW+1)'(1 << (WEIGHT_FRAC-1)) : (PW+1)'(0);
  localparam logic signed [PW:0]   SAT_MAX = (PW+1)'((1 << (SW-1)) - 1);
  localparam logic signed [PW:0]   SAT_MIN = (PW+1)'(-(1 << (SW-1)));

  logic advance, accept, activate;
  logic signed [WW-1:0] active_wr_reg, active_wi_reg, shadow_wr_reg, shadow_wi_reg;
  logic signed [WW-1:0] wr_use, wi_use;
  logic pending_reg, frame_start_reg;

  logic s1_valid_reg, s1_last_reg, s2_valid_reg, s2_last_reg;
  logic signed [WW-1:0] s1_wr_reg, s1_wi_reg;
  logic signed [PW-1:0] wr_ext, wi_ext;

  logic m_valid_reg, m_last_reg, ovf_reg, ovf_event;
  logic [DW-1:0] m_re_reg, m_im_reg, out_re_next, out_im_next;
  logic [SAMPLES-1:0] lane_ovf;

  assign advance       = ~m_valid_reg | m_axis_tready;
  assign s_axis_tready = advance & ~reset;
  assign accept        = s_axis_tvalid & s_axis_tready;
  // A pending weight takes effect on the first beat of a frame, including the very beat that activates it.
  assign activate      = accept & frame_start_reg & pending_reg;
  assign wr_use        = activate ? shadow_wr_reg : active_wr_reg;
  assign wi_use        = activate ? shadow_wi_reg : active_wi_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_wr_reg   <= W_ONE;
      active_wi_reg   <= '0;
      shadow_wr_reg   <= '0;
      shadow_wi_reg   <= '0;
      pending_reg     <= 1'b0;
      frame_start_reg <= 1'b1;
    end else begin
      if (activate) begin
        active_wr_reg <= shadow_wr_reg;
        active_wi_reg <= shadow_wi_reg;
      end
      if (w_load) begin
        shadow_wr_reg <= w_real;
        shadow_wi_reg <= w_imag;
        pending_reg   <= 1'b1;
      end else if (activate) begin
        pending_reg   <= 1'b0;
      end
      if (accept) frame_start_reg <= s_axis_tlast;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_wr_reg    <= '0;
      s1_wi_reg    <= '0;
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      m_re_reg     <= '0;
      m_im_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (advance) begin
        s1_valid_reg <= accept;
        s1_last_reg  <= accept & s_axis_tlast;
        s1_wr_reg    <= wr_use;
        s1_wi_reg    <= wi_use;
        s2_valid_reg <= s1_valid_reg;
        s2_last_reg  <= s1_last_reg;
        m_valid_reg  <= s2_valid_reg;
        m_last_reg   <= s2_last_reg;
        m_re_reg     <= out_re_next;
        m_im_reg     <= out_im_next;
      end
      if (ovf_event)      ovf_reg <= 1'b1;
      else if (ovf_clear) ovf_reg <= 1'b0;
    end
  end

  assign ovf_event = advance & s2_valid_reg & (|lane_ovf);
  assign wr_ext    = $signed({{SW{s1_wr_reg[WW-1]}}, s1_wr_reg});
  assign wi_ext    = $signed({{SW{s1_wi_reg[WW-1]}}, s1_wi_reg});

  genvar gi;
  generate
    for (gi = 0; gi < SAMPLES; gi++) begin : g_lane
      logic signed [SW-1:0] xr_reg, xi_reg;
      logic signed [PW-1:0] xr_ext, xi_ext;
      logic signed [PW-1:0] p_rr_reg, p_ii_reg, p_ri_reg, p_ir_reg;
      logic signed [PW:0]   re_sum, im_sum, re_sh, im_sh;
      logic                 re_hi, re_lo, im_hi, im_lo;

      assign xr_ext = $signed({{WW{xr_reg[SW-1]}}, xr_reg});
      assign xi_ext = $signed({{WW{xi_reg[SW-1]}}, xi_reg});

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          xr_reg   <= '0;
          xi_reg   <= '0;
          p_rr_reg <= '0;
          p_ii_reg <= '0;
          p_ri_reg <= '0;
          p_ir_reg <= '0;
        end else if (advance) begin
          xr_reg   <= s_axis_real_tdata[gi*SW +: SW];
          xi_reg   <= s_axis_imag_tdata[gi*SW +: SW];
          p_rr_reg <= xr_ext * wr_ext;
          p_ii_reg <= xi_ext * wi_ext;
          p_ri_reg <= xr_ext * wi_ext;
          p_ir_reg <= xi_ext * wr_ext;
        end
      end

      // One guard bit above the product width holds the sum and rounding offset without overflow.
      assign re_sum = $signed({p_rr_reg[PW-1], p_rr_reg}) - $signed({p_ii_reg[PW-1], p_ii_reg}) + RND;
      assign im_sum = $signed({p_ri_reg[PW-1], p_ri_reg}) + $signed({p_ir_reg[PW-1], p_ir_reg}) + RND;
      assign re_sh  = re_sum >>> WEIGHT_FRAC;
      assign im_sh  = im_sum >>> WEIGHT_FRAC;
      assign re_hi  = re_sh > SAT_MAX;
      assign re_lo  = re_sh < SAT_MIN;
      assign im_hi  = im_sh > SAT_MAX;
      assign im_lo  = im_sh < SAT_MIN;
      assign lane_ovf[gi] = re_hi | re_lo | im_hi | im_lo;

      assign out_re_next[gi*SW +: SW] = (SATURATE != 0 && re_hi) ? SAT_MAX[SW-1:0] :
                                        (SATURATE != 0 && re_lo) ? SAT_MIN[SW-1:0] : re_sh[SW-1:0];
      assign out_im_next[gi*SW +: SW] = (SATURATE != 0 && im_hi) ? SAT_MAX[SW-1:0] :
                                        (SATURATE != 0 && im_lo) ? SAT_MIN[SW-1:0] : im_sh[SW-1:0];
    end
  endgenerate

  assign w_pending         = pending_reg;
  assign m_axis_real_tdata = m_re_reg;
  assign m_axis_imag_tdata = m_im_reg;
  assign m_axis_tkeep      = {KW{m_valid_reg}};
  assign m_axis_tvalid     = m_valid_reg;
  assign m_axis_tlast      = m_last_reg;
  assign ovf_sticky        = ovf_reg;
endmodule

// File: tb/tb_axis_cmult_bf_pipe.sv
// Scoreboard bench for axis_cmult_bf_pipe: directed frames push hand-derived results,
// a negedge monitor pops and compares every output handshake.
module tb_axis_cmult_bf_pipe;
  localparam int N  = 8;
  localparam int SW = 16;
  localparam int DW = N * SW;
  localparam int KW = DW / 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] w_real = '0, w_imag = '0;
  logic w_load = 1'b0, w_pending;
  logic [DW-1:0] s_real = '0, s_imag = '0;
  logic s_valid = 1'b0, s_tready, s_last = 1'b0;
  logic [DW-1:0] m_re, m_im;
  logic [KW-1:0] m_keep;
  logic m_tvalid, m_tready = 1'b1, m_tlast;
  logic ovf_sticky, ovf_clear = 1'b0;

  always #5 clock = ~clock;

  axis_cmult_bf_pipe dut (
    .clock(clock), .reset(reset),
    .w_real(w_real), .w_imag(w_imag), .w_load(w_load), .w_pending(w_pending),
    .s_axis_real_tdata(s_real), .s_axis_imag_tdata(s_imag),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_tready), .s_axis_tlast(s_last),
    .m_axis_real_tdata(m_re), .m_axis_imag_tdata(m_im), .m_axis_tkeep(m_keep),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  typedef struct { logic [DW-1:0] re; logic [DW-1:0] im; logic last; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0, accepted = 0, n_out = 0;
  logic [DW-1:0] hold_re, hold_im;
  logic hold_last, stalled = 1'b0;

  function automatic logic [DW-1:0] lanes(input int base, input int step);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = 16'(base + i * step);
    return v;
  endfunction

  function automatic logic [DW-1:0] alt(input int a, input int b);
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*SW +: SW] = 16'((i % 2 == 0) ? a : b);
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record its expected result.
  task automatic send(input logic [DW-1:0] xr, input logic [DW-1:0] xi,
                      input logic [DW-1:0] er, input logic [DW-1:0] ei, input logic last,
                      input logic load, input logic [7:0] lr, input logic [7:0] li);
    int t = 0;
    s_real = xr; s_imag = xi; s_last = last; s_valid = 1'b1;
    if (load) begin w_real = lr; w_imag = li; w_load = 1'b1; end
    @(negedge clock);
    while (!s_tready && t < 200) begin @(negedge clock); t++; end
    if (!s_tready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: s_axis_tready stayed 0 for %0d cycles, required 1", t);
    end else begin
      @(posedge clock);
      sb.push_back('{er, ei, last});
      accepted++;
    end
    #1;
    s_valid = 1'b0; s_last = 1'b0; w_load = 1'b0;
  endtask

  task automatic load_w(input logic [7:0] lr, input logic [7:0] li);
    w_real = lr; w_imag = li; w_load = 1'b1;
    @(posedge clock); #1;
    w_load = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 100) begin @(posedge clock); #1; t++; end
    @(posedge clock); #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still outstanding, required 0", sb.size());
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", {127'b0, m_tvalid}, 1);
          check("stall_re", m_re, hold_re);
          check("stall_im", m_im, hold_im);
          check("stall_last", {127'b0, m_tlast}, {127'b0, hold_last});
        end
        if (m_tvalid && m_tready) begin
          stalled = 1'b0;
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: output beat re0=%0d with empty scoreboard", $signed(m_re[15:0]));
          end else begin
            e = sb.pop_front();
            n_out++;
            check("beat_re", m_re, e.re);
            check("beat_im", m_im, e.im);
            check("beat_last", {127'b0, m_tlast}, {127'b0, e.last});
            check("beat_keep", {112'b0, m_keep}, {112'b0, {KW{1'b1}}});
            $display("[TB] out beat %0d re0=%0d im0=%0d re7=%0d last=%0b", n_out,
                     $signed(m_re[15:0]), $signed(m_im[15:0]), $signed(m_re[127:112]), m_tlast);
          end
        end else if (m_tvalid) begin
          stalled = 1'b1; hold_re = m_re; hold_im = m_im; hold_last = m_tlast;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base, t;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tready", {127'b0, s_tready}, 0);
    check("rst_tvalid", {127'b0, m_tvalid}, 0);
    check("rst_tlast", {127'b0, m_tlast}, 0);
    check("rst_tkeep", {112'b0, m_keep}, 0);
    check("rst_re", m_re, 0);
    check("rst_im", m_im, 0);
    check("rst_pending", {127'b0, w_pending}, 0);
    check("rst_ovf", {127'b0, ovf_sticky}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // unity default weight
    send(lanes(1000, 0), lanes(-200, 0), lanes(1000, 0), lanes(-200, 0), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();

    // multiply by j
    load_w(8'd0, 8'd64);
    check("pending_set", {127'b0, w_pending}, 1);
    send(lanes(1000, 0), lanes(500, 0), lanes(-500, 0), lanes(1000, 0), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();
    check("pending_clr", {127'b0, w_pending}, 0);

    // rounding with half weight: 1.5 -> 2, -1.5 -> -1
    load_w(8'd32, 8'd0);
    send(alt(3, -3), lanes(0, 0), alt(2, -1), lanes(0, 0), 1'b0, 1'b0, 8'd0, 8'd0);
    send(lanes(-3, 0), lanes(0, 0), lanes(-1, 0), lanes(0, 0), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();
    check("ovf_quiet", {127'b0, ovf_sticky}, 0);

    // saturation
    load_w(8'd127, 8'd127);
    send(lanes(32767, 0), lanes(-32768, 0), lanes(32767, 0), lanes(-2, 0), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();
    check("ovf_set", {127'b0, ovf_sticky}, 1);
    ovf_clear = 1'b1;
    @(posedge clock); #1;
    ovf_clear = 1'b0;
    check("ovf_cleared", {127'b0, ovf_sticky}, 0);

    // backpressure: identity weight, 10-beat frame, 5-cycle stall mid-frame
    load_w(8'd64, 8'd0);
    base = accepted;
    fork
      begin
        for (int b = 1; b <= 10; b++)
          send(lanes(100 * b, 3), lanes(-10 * b, -1), lanes(100 * b, 3), lanes(-10 * b, -1),
               (b == 10), 1'b0, 8'd0, 8'd0);
      end
      begin
        t = 0;
        while (accepted < base + 4 && t < 500) begin @(posedge clock); t++; end
        #1; m_tready = 1'b0;
        repeat (5) @(posedge clock);
        #1; m_tready = 1'b1;
      end
    join
    drain();
    check("bp_count", 128'(accepted - base), 10);
    check("ovf_clean", {127'b0, ovf_sticky}, 0);

    // weight staged mid-frame applies only from the next frame
    for (int b = 1; b <= 6; b++)
      send(lanes(20 * b, 5), lanes(7 * b + 1, -2), lanes(20 * b, 5), lanes(7 * b + 1, -2),
           (b == 6), (b == 4), 8'd0, 8'd64);
    drain();
    check("pending_hold", {127'b0, w_pending}, 1);
    send(lanes(300, 1), lanes(-40, 2), lanes(40, -2), lanes(300, 1), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();
    check("pending_done", {127'b0, w_pending}, 0);

    // reset with a beat in flight: discarded, weight back to unity
    send(lanes(5, 0), lanes(5, 0), lanes(0, 0), lanes(0, 0), 1'b0, 1'b0, 8'd0, 8'd0);
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    check("midrst_tvalid", {127'b0, m_tvalid}, 0);
    check("midrst_tready", {127'b0, s_tready}, 0);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midrst_no_out", {127'b0, m_tvalid}, 0);
    send(lanes(1000, 0), lanes(-200, 0), lanes(1000, 0), lanes(-200, 0), 1'b1, 1'b0, 8'd0, 8'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_cmult_bf_pipe.md
Name: axis_cmult_bf_pipe

Overview:
Parametrised complex beamforming multiplier: applies one signed fixed-point complex weight to every complex sample of an AXI-Stream beat (real and imaginary lanes carried in parallel buses under one handshake). It is a fully back-pressurable 3-stage pipeline with selectable rounding and saturation, frame-aligned weight updates and sticky overflow reporting. It sits between the ADC channel DMA source and the beam summation/S2MM path.

Parameters:
SAMPLES, 8, complex samples per beat
SAMPLE_WIDTH, 16, signed input/output sample width
WEIGHT_WIDTH, 8, signed weight component width
WEIGHT_FRAC, 6, fractional bits of weight (1.0 = 64)
ROUND, 1, 1 = round-half-up, 0 = truncate (floor)
SATURATE, 1, 1 = clamp to SAMPLE_WIDTH range, 0 = wrap

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
w_real  in  WEIGHT_WIDTH  staged weight, real part (signed)
w_imag  in  WEIGHT_WIDTH  staged weight, imaginary part (signed)
w_load  in  1  pulse: capture w_real/w_imag into shadow register
w_pending  out  1  shadow weight captured, not yet active
s_axis_real_tdata  in  SAMPLES*SAMPLE_WIDTH  real lanes, sample 0 in LSBs
s_axis_imag_tdata  in  SAMPLES*SAMPLE_WIDTH  imaginary lanes
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid & tready
s_axis_tlast  in  1  last beat of frame
m_axis_real_tdata  out  SAMPLES*SAMPLE_WIDTH  weighted real lanes
m_axis_imag_tdata  out  SAMPLES*SAMPLE_WIDTH  weighted imaginary lanes
m_axis_tkeep  out  SAMPLES*SAMPLE_WIDTH/8  all ones when tvalid
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  tlast delayed with its beat
ovf_sticky  out  1  set on any saturation/wrap event
ovf_clear  in  1  clears ovf_sticky

Behaviour:
- Reset (async assert, sync release): all stage valids 0, m_axis_tvalid 0, m_axis_tlast 0, tdata 0, tkeep 0, active weight = (2^WEIGHT_FRAC, 0) (unity), shadow empty, w_pending 0, ovf_sticky 0. s_axis_tready 0 while reset is high.
- Pipeline: S1 register inputs + active weight; S2 four products xr*wr, xi*wi, xr*wi, xi*wr (SAMPLE_WIDTH+WEIGHT_WIDTH signed); S3 re = xr*wr - xi*wi, im = xr*wi + xi*wr at full width (+1 bit), scale, round, saturate, register to output. Latency 3 cycles from acceptance to m_axis_tvalid with no stall.
- Global enable: advance = ~m_axis_tvalid | m_axis_tready. All stages shift only when advance=1. s_axis_tready = advance (combinational, 0 in reset). Bubbles propagate as valid=0; no bubble collapsing is required. While stalled, m_axis outputs are held stable.
- tlast travels in lockstep with its beat; tkeep is all ones on every valid beat, 0 otherwise.
- Scaling: result >> WEIGHT_FRAC arithmetic. ROUND=1: add 2^(WEIGHT_FRAC-1) before shift (ties toward +inf). ROUND=0: plain arithmetic shift (floor).
- SATURATE=1: clamp to [-2^(SW-1), 2^(SW-1)-1]; SATURATE=0: keep the low SW bits. In either mode, a lane out of range sets ovf_sticky on the cycle the beat enters S3 (S3 advance only).
- ovf_clear has priority over a simultaneous set only if no overflow is occurring that cycle; a simultaneous overflow leaves ovf_sticky=1.
- Weights: w_load captures into shadow and sets w_pending; a second load before activation overwrites the shadow. The shadow becomes active, and w_pending clears, on the first accepted input beat that follows an accepted tlast beat. With no traffic since reset, the first accepted beat also activates it. A beat is always weighted entirely by one weight, never mixed.
- Reset mid-frame: in-flight beats are discarded, no output handshake completes, weight returns to unity.

Test Plan:
- Unity weight default: xr=1000, xi=-200 on all lanes -> out re=1000, im=-200 after 3 cycles, tkeep all ones.
- w=(0,64), xr=1000, xi=500 -> re=-500, im=1000 on every lane.
- Rounding: w=(32,0), xr=3 -> 2 (ROUND=1) / 1 (ROUND=0); xr=-3 -> -1 (ROUND=1) / -2 (ROUND=0).
- Saturation: w=(127,127), xr=32767, xi=-32768 -> re=32767, ovf_sticky=1; ovf_clear pulse with clean traffic -> 0.
- Backpressure: 10-beat frame, m_axis_tready low for 5 cycles mid-frame -> all 10 beats out in order, none lost or duplicated, data stable while stalled, tlast only on beat 10.
- Weight update: w_load (0,64) at beat 4 of a 6-beat frame -> beats 1-6 use the old weight, w_pending=1 until the next frame's first beat, which uses the new weight.
